// File: rtl/scaled_sample_accumulator.sv
// scaled_sample_accumulator: serial shift-add scaler feeding
// CHANNELS saturating accumulators behind a valid/ready handshake.
module scaled_sample_accumulator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DIVISOR_BITS = 7,
  parameter int ACC_WIDTH    = 32,
  parameter int CHANNELS     = 2,
  parameter int CHANNEL_BITS = 1
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset_n,
  input  logic                    i_Clear,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  input  logic [CHANNEL_BITS-1:0] i_Channel,
  input  logic                    i_Subtract,
  input  logic [DIVISOR_BITS-1:0] i_Multiple,
  input  logic [SAMPLE_WIDTH-1:0] i_Sample,
  input  logic [CHANNEL_BITS-1:0] i_Read_Channel,
  output logic [ACC_WIDTH-1:0]    o_Accumulator,
  output logic                    o_Saturated,
  output logic                    o_Done
);

  localparam int PW = SAMPLE_WIDTH + DIVISOR_BITS;
  localparam int SHW = $clog2(DIVISOR_BITS + 1);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [PW-1:0]     sample_q;
  logic signed [PW-1:0]     product_q;
  logic [DIVISOR_BITS-1:0]  remaining_q;
  logic [SHW-1:0]           shift_q;
  logic [CHANNEL_BITS-1:0]  channel_q;
  logic                     subtract_q;

  logic signed [ACC_WIDTH-1:0] acc_q [CHANNELS];
  logic                        sat_q [CHANNELS];

  logic                        accept;
  logic                        step;
  logic                        commit;
  logic                        ch_ok;
  logic                        rd_ok;
  logic signed [PW-1:0]        sample_ext;
  logic signed [ACC_WIDTH-1:0] acc_sel;
  logic signed [ACC_WIDTH:0]   acc_x;
  logic signed [ACC_WIDTH:0]   scaled_x;
  logic signed [ACC_WIDTH:0]   sum_x;
  logic                        ovf;
  logic [ACC_WIDTH-1:0]        acc_new;

  assign o_Ready = (state_q == IDLE);

  assign accept = i_Valid && o_Ready && !i_Clear;
  assign step   = (state_q == BUSY) && (remaining_q != '0);
  assign commit = (state_q == BUSY) && (remaining_q == '0)
                  && !i_Clear;

  assign ch_ok = (32'(channel_q) < CHANNELS);
  assign rd_ok = (32'(i_Read_Channel) < CHANNELS);

  assign sample_ext =
    {{DIVISOR_BITS{i_Sample[SAMPLE_WIDTH-1]}}, i_Sample};

  // State register
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: clear always returns to idle and drops any work
  always_comb begin
    state_d = state_q;
    if (i_Clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (i_Valid) state_d = BUSY;
        BUSY: if (remaining_q == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Serial multiplier: one numerator bit per busy cycle
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sample_q    <= '0;
      product_q   <= '0;
      remaining_q <= '0;
      shift_q     <= '0;
      channel_q   <= '0;
      subtract_q  <= 1'b0;
    end else if (accept) begin
      sample_q    <= sample_ext;
      product_q   <= i_Multiple[0] ? sample_ext : '0;
      remaining_q <= i_Multiple >> 1;
      shift_q     <= SHW'(1);
      channel_q   <= i_Channel;
      subtract_q  <= i_Subtract;
    end else if (step && !i_Clear) begin
      if (remaining_q[0]) begin
        product_q <= product_q + (sample_q <<< shift_q);
      end
      remaining_q <= remaining_q >> 1;
      shift_q     <= shift_q + SHW'(1);
    end
  end

  // Floor-scale, add/subtract one bit wider, then clamp
  always_comb begin
    acc_sel = '0;
    if (ch_ok) begin
      acc_sel = acc_q[channel_q];
    end
    acc_x    = {acc_sel[ACC_WIDTH-1], acc_sel};
    scaled_x = (ACC_WIDTH+1)'(product_q >>> DIVISOR_BITS);
    sum_x    = subtract_q ? (acc_x - scaled_x)
                          : (acc_x + scaled_x);
    ovf      = sum_x[ACC_WIDTH] != sum_x[ACC_WIDTH-1];
    acc_new  = sum_x[ACC_WIDTH-1:0];
    if (ovf) begin
      acc_new = sum_x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  // Accumulator bank; clear wins over a same-cycle commit
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        sat_q[i] <= 1'b0;
      end
    end else if (i_Clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        sat_q[i] <= 1'b0;
      end
    end else if (commit && ch_ok) begin
      acc_q[channel_q] <= acc_new;
      if (ovf) begin
        sat_q[channel_q] <= 1'b1;
      end
    end
  end

  // Registered read port and completion pulse
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Accumulator <= '0;
      o_Saturated   <= 1'b0;
      o_Done        <= 1'b0;
    end else begin
      o_Accumulator <= rd_ok ? acc_q[i_Read_Channel] : '0;
      o_Saturated   <= rd_ok ? sat_q[i_Read_Channel] : 1'b0;
      o_Done        <= commit;
    end
  end

endmodule

// File: doc/scaled_sample_accumulator.md
# scaled_sample_accumulator

Parametrised multi-channel scale-and-accumulate engine. Each accepted sample is multiplied by a fractional factor (i_Multiple / 2^DIVISOR_BITS) using a serial shift-add. The scaled result is added to, or subtracted from, one of CHANNELS independent saturating accumulators. It sits between the per-harmonic sample generators and the output mixer. A valid/ready handshake, a synchronous frame clear and per-channel overflow flags replace the earlier single-accumulator, async-clear scheme.

## Interface
- SAMPLE_WIDTH, 16, signed input sample width
- DIVISOR_BITS, 7, fraction resolution; scale factor = i_Multiple / 2^DIVISOR_BITS
- ACC_WIDTH, 32, signed accumulator width; must be ≥ SAMPLE_WIDTH
- CHANNELS, 2, number of accumulators; ≥ 1
- CHANNEL_BITS, 1, channel index width; 2^CHANNEL_BITS ≥ CHANNELS

- i_Clock  in  1  system clock, rising edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Clear  in  1  synchronous clear of all accumulators and flags
- i_Valid  in  1  request; transfer occurs when i_Valid && o_Ready at the clock edge
- o_Ready  out  1  engine idle, able to accept
- i_Channel  in  CHANNEL_BITS  destination accumulator
- i_Subtract  in  1  0 = add scaled value, 1 = subtract it
- i_Multiple  in  DIVISOR_BITS  unsigned scale numerator
- i_Sample  in  SAMPLE_WIDTH  signed sample
- i_Read_Channel  in  CHANNEL_BITS  selects the channel shown on the outputs
- o_Accumulator  out  ACC_WIDTH  registered value of the selected accumulator
- o_Saturated  out  1  registered sticky saturation flag of the selected channel
- o_Done  out  1  one-cycle pulse on the cycle an accumulator is committed

## Operation
- States: IDLE (o_Ready=1) and BUSY (o_Ready=0).
- Accept in IDLE: latch sample, channel and subtract bit.
  - product = i_Multiple[0] ? sample : 0
  - remaining = i_Multiple >> 1, shift = 1
  - Go to BUSY.
- BUSY, remaining ≠ 0, each cycle:
  - If remaining[0] is set, add (sample << shift) to product.
  - remaining >>= 1, shift += 1.
- BUSY, remaining == 0 (commit cycle):
  - scaled = product >>> DIVISOR_BITS, an arithmetic shift, i.e. floor division; sign-extend to ACC_WIDTH.
  - acc[ch] = acc[ch] ± scaled, computed at ACC_WIDTH+1 bits.
  - Clamp to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. When clamping occurs, set sat[ch].
  - Pulse o_Done and return to IDLE.
- Product register width is SAMPLE_WIDTH+DIVISOR_BITS, signed; no intermediate overflow is possible.
- i_Channel ≥ CHANNELS: the transaction runs normally and o_Done pulses, but no accumulator or flag changes.
- i_Multiple = 0: the result is 0. The accumulator is rewritten unchanged and o_Done pulses.
- Outputs: o_Accumulator and o_Saturated register acc[i_Read_Channel] and sat[i_Read_Channel] every cycle. An out-of-range read channel gives 0 / 0.
- i_Clear = 1:
  - Zeroes all acc and sat.
  - Aborts any BUSY operation: state goes to IDLE, no o_Done.
  - Blocks acceptance that cycle (o_Ready is still 1 when idle, but a transfer is ignored).
  - Clear beats a simultaneous commit.
- Async reset:
  - Reset values: state IDLE, all acc/sat = 0, o_Ready = 1, o_Done = 0, o_Accumulator = 0, o_Saturated = 0.
  - Reset mid-operation discards the operation.

## Timing
- Let p = index of the highest set bit of i_Multiple, with p = 0 for i_Multiple ≤ 1.
- Accept at edge T0. The BUSY shift-add cycles occupy edges T0+1 … T0+p.
- Commit at edge T0+p+1:
  - o_Done is high for the cycle following that edge.
  - o_Ready returns to 1 in the same cycle.
- The earliest next acceptance is at edge T0+p+2. Worst-case occupancy is DIVISOR_BITS+1 cycles.
- o_Accumulator shows the committed value from edge T0+p+2, one register stage after the commit.
- Inputs other than i_Valid, i_Read_Channel and i_Clear are don't-care while o_Ready = 0.
- o_Ready is registered and does not depend combinationally on i_Valid.

## Test plan
- Reset, then add S=1000, M=64, ch 0 → o_Done 7 cycles after accept; o_Accumulator = 500 one cycle later; ch 1 stays 0.
- S=−3, M=64, add, ch 1 → acc1 = −2 (floor of −1.5); the following S=−3, M=64 with i_Subtract=1 gives acc1 = 0.
- ACC_WIDTH=16: S=32767, M=127 added twice to ch 0 → first commit gives 32511; second clamps to 32767 with o_Saturated = 1; sat persists until i_Clear.
- M=0 and M=1 with S=−200 → the commit arrives 1 cycle after accept; results 0 and −2 (floor of −200/128 = −1.5625).
- i_Clear asserted 3 cycles into an M=127 operation → no o_Done; all accumulators read 0; o_Ready = 1 next cycle; a new transfer is accepted normally.
- i_Reset_n pulsed low mid-operation and back-to-back transfers with i_Valid held high → outputs reset asynchronously; each transfer is accepted exactly once, p+2 cycles apart.
